// File: rtl/rl_pair_filter_arbiter.sv
// Cutoff filter for RL candidate pairs: per-lane FIFOs for kept pairs, one
// round-robin pop per cycle toward the RL evaluation pipeline.
module rl_pair_filter_arbiter #(
   parameter int unsigned            DATA_WIDTH      = 32,
   parameter int unsigned            NUM_FILTER      = 4,
   parameter int unsigned            FILTER_ID_WIDTH = 2,
   parameter int unsigned            FIFO_DEPTH      = 8,
   parameter int unsigned            FIFO_ADDR_WIDTH = 3,
   parameter logic [DATA_WIDTH-1:0]  CUTOFF_2        = 32'h43100000
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic [NUM_FILTER-1:0]            in_valid,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_r2,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_dx,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_dy,
   input  logic [NUM_FILTER*DATA_WIDTH-1:0] in_dz,
   output logic [NUM_FILTER-1:0]            in_ready,
   output logic                             r2_valid,
   output logic [DATA_WIDTH-1:0]            r2,
   output logic [DATA_WIDTH-1:0]            dx,
   output logic [DATA_WIDTH-1:0]            dy,
   output logic [DATA_WIDTH-1:0]            dz,
   output logic [FILTER_ID_WIDTH-1:0]       out_lane,
   output logic [15:0]                      reject_count
);

   localparam int unsigned CNT_W = FIFO_ADDR_WIDTH + 1;
   localparam int unsigned REJ_W = $clog2(NUM_FILTER + 1);

   logic [DATA_WIDTH-1:0]      mem_r2 [NUM_FILTER][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      mem_dx [NUM_FILTER][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      mem_dy [NUM_FILTER][FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]      mem_dz [NUM_FILTER][FIFO_DEPTH];
   logic [FIFO_ADDR_WIDTH-1:0] wr_ptr [NUM_FILTER];
   logic [FIFO_ADDR_WIDTH-1:0] rd_ptr [NUM_FILTER];
   logic [CNT_W-1:0]           count  [NUM_FILTER];
   logic [FILTER_ID_WIDTH-1:0] last_grant;

   logic [NUM_FILTER-1:0]      full;
   logic [NUM_FILTER-1:0]      push;
   logic [NUM_FILTER-1:0]      pop;
   logic [REJ_W-1:0]           rej_cnt;
   logic [16:0]                rej_sum;
   logic [15:0]                reject_next;
   logic [DATA_WIDTH-1:0]      lane_r2;
   logic                       keep;
   logic                       grant_valid;
   logic [FILTER_ID_WIDTH-1:0] grant_lane;
   int                         idx;

   function automatic logic [FIFO_ADDR_WIDTH-1:0] ptr_inc(input logic [FIFO_ADDR_WIDTH-1:0] p);
      return (p == FIFO_ADDR_WIDTH'(FIFO_DEPTH - 1)) ? '0 : p + FIFO_ADDR_WIDTH'(1);
   endfunction

   // Ready reflects registered occupancy only, so a same-cycle pop never opens a slot early
   always_comb begin
      full = '0;
      for (int i = 0; i < NUM_FILTER; i++) begin
         full[i] = (count[i] >= CNT_W'(FIFO_DEPTH));
      end
      in_ready = rst ? '1 : ~full;
   end

   // Cutoff test on the raw IEEE bits: sign clear, non-zero magnitude, magnitude below cutoff
   always_comb begin
      push    = '0;
      rej_cnt = '0;
      lane_r2 = '0;
      keep    = 1'b0;
      for (int i = 0; i < NUM_FILTER; i++) begin
         lane_r2 = in_r2[i*DATA_WIDTH +: DATA_WIDTH];
         keep    = !lane_r2[DATA_WIDTH-1]
                   && (lane_r2[DATA_WIDTH-2:0] != '0)
                   && (lane_r2[DATA_WIDTH-2:0] < CUTOFF_2[DATA_WIDTH-2:0]);
         if (!rst && in_valid[i] && !full[i]) begin
            if (keep) begin
               push[i] = 1'b1;
            end else begin
               rej_cnt = rej_cnt + REJ_W'(1);
            end
         end
      end
      rej_sum     = {1'b0, reject_count} + 17'(rej_cnt);
      reject_next = rej_sum[16] ? 16'hFFFF : rej_sum[15:0];
   end

   // Round-robin search begins just past the last granted lane
   always_comb begin
      grant_valid = 1'b0;
      grant_lane  = '0;
      pop         = '0;
      idx         = 0;
      for (int k = 0; k < NUM_FILTER; k++) begin
         idx = (int'(last_grant) + k + 1) % int'(NUM_FILTER);
         if (!grant_valid && (count[idx] != '0)) begin
            grant_valid = 1'b1;
            grant_lane  = FILTER_ID_WIDTH'(idx);
         end
      end
      if (!rst && grant_valid) begin
         pop[grant_lane] = 1'b1;
      end
   end

   // Storage arrays carry no reset; push is held low while rst is high
   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_FILTER; i++) begin
         if (push[i]) begin
            mem_r2[i][wr_ptr[i]] <= in_r2[i*DATA_WIDTH +: DATA_WIDTH];
            mem_dx[i][wr_ptr[i]] <= in_dx[i*DATA_WIDTH +: DATA_WIDTH];
            mem_dy[i][wr_ptr[i]] <= in_dy[i*DATA_WIDTH +: DATA_WIDTH];
            mem_dz[i][wr_ptr[i]] <= in_dz[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_FILTER; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
            count[i]  <= '0;
         end
         last_grant   <= FILTER_ID_WIDTH'(NUM_FILTER - 1);
         r2_valid     <= 1'b0;
         r2           <= '0;
         dx           <= '0;
         dy           <= '0;
         dz           <= '0;
         out_lane     <= '0;
         reject_count <= '0;
      end else begin
         for (int i = 0; i < NUM_FILTER; i++) begin
            if (push[i]) begin
               wr_ptr[i] <= ptr_inc(wr_ptr[i]);
            end
            if (pop[i]) begin
               rd_ptr[i] <= ptr_inc(rd_ptr[i]);
            end
            case ({push[i], pop[i]})
               2'b10:   count[i] <= count[i] + CNT_W'(1);
               2'b01:   count[i] <= count[i] - CNT_W'(1);
               default: count[i] <= count[i];
            endcase
         end
         r2_valid <= grant_valid;
         if (grant_valid) begin
            r2         <= mem_r2[grant_lane][rd_ptr[grant_lane]];
            dx         <= mem_dx[grant_lane][rd_ptr[grant_lane]];
            dy         <= mem_dy[grant_lane][rd_ptr[grant_lane]];
            dz         <= mem_dz[grant_lane][rd_ptr[grant_lane]];
            out_lane   <= grant_lane;
            last_grant <= grant_lane;
         end
         reject_count <= reject_next;
      end
   end

endmodule

// File: tb/tb_rl_pair_filter_arbiter.sv
// Bench for rl_pair_filter_arbiter: queue-based reference model checked every
// cycle, a filter vector table, and directed multi-cycle sequences.
module tb_rl_pair_filter_arbiter;

   logic         clk;
   logic         rst;
   logic [3:0]   in_valid;
   logic [127:0] in_r2, in_dx, in_dy, in_dz;
   logic [3:0]   in_ready;
   logic         r2_valid;
   logic [31:0]  r2, dx, dy, dz;
   logic [1:0]   out_lane;
   logic [15:0]  reject_count;

   int checks = 0;
   int errors = 0;

   // reference model state: per-lane queues of {r2,dx,dy,dz}
   logic [127:0] q [4][$];
   int           m_lg;
   int           m_rc;
   logic         m_v;
   logic [31:0]  m_r2, m_dx, m_dy, m_dz;
   logic [1:0]   m_lane;

   rl_pair_filter_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_r2        (in_r2),
      .in_dx        (in_dx),
      .in_dy        (in_dy),
      .in_dz        (in_dz),
      .in_ready     (in_ready),
      .r2_valid     (r2_valid),
      .r2           (r2),
      .dx           (dx),
      .dy           (dy),
      .dz           (dz),
      .out_lane     (out_lane),
      .reject_count (reject_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // kept iff a positive, non-zero, finite value strictly below 144.0 (bit-pattern order)
   function automatic bit keep_r2(input logic [31:0] r);
      return (r[31] == 1'b0) && (r[30:0] != 31'd0) && (r[30:0] < 31'h43100000);
   endfunction

   // one clock: drive inputs, advance model, check ready before and outputs after the edge
   task automatic cycle(input logic [3:0] v, input logic [127:0] r2v, dxv, dyv, dzv);
      logic [3:0]   er;
      logic [127:0] e;
      int           g;
      int           l;
      in_valid = v;
      in_r2    = r2v;
      in_dx    = dxv;
      in_dy    = dyv;
      in_dz    = dzv;
      #1;
      er = 4'hF;
      if (rst) begin
         for (int i = 0; i < 4; i++) q[i].delete();
         m_lg = 3; m_rc = 0; m_v = 1'b0;
         m_r2 = '0; m_dx = '0; m_dy = '0; m_dz = '0; m_lane = '0;
      end else begin
         for (int i = 0; i < 4; i++) er[i] = (q[i].size() < 8);
         g = -1;
         for (int k = 0; k < 4; k++) begin
            l = (m_lg + 1 + k) % 4;
            if (g < 0 && q[l].size() > 0) g = l;
         end
         for (int i = 0; i < 4; i++) begin
            if (v[i] && er[i]) begin
               if (keep_r2(r2v[i*32 +: 32]))
                  q[i].push_back({r2v[i*32 +: 32], dxv[i*32 +: 32], dyv[i*32 +: 32], dzv[i*32 +: 32]});
               else
                  m_rc = (m_rc >= 65535) ? 65535 : m_rc + 1;
            end
         end
         m_v = (g >= 0);
         if (g >= 0) begin
            e = q[g].pop_front();
            {m_r2, m_dx, m_dy, m_dz} = e;
            m_lane = 2'(g);
            m_lg   = g;
         end
      end
      chk("in_ready", 32'(in_ready), 32'(er));
      @(posedge clk);
      #1;
      chk("r2_valid", 32'(r2_valid), 32'(m_v));
      chk("r2", r2, m_r2);
      chk("dx", dx, m_dx);
      chk("dy", dy, m_dy);
      chk("dz", dz, m_dz);
      chk("out_lane", 32'(out_lane), 32'(m_lane));
      chk("reject_count", 32'(reject_count), 32'(m_rc));
   endtask

   task automatic idle();
      cycle(4'h0, '0, '0, '0, '0);
   endtask

   task automatic reset_pulse();
      rst = 1'b1;
      idle();
      rst = 1'b0;
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   function automatic logic [31:0] gen_r2();
      logic [31:0] specials [7];
      specials[0] = 32'h00000000; specials[1] = 32'h80000000; specials[2] = 32'h43100000;
      specials[3] = 32'h7F800000; specials[4] = 32'h7FC00000; specials[5] = 32'h430FFFFF;
      specials[6] = 32'h00000001;
      case ($urandom_range(0, 4))
         0, 1:    return 32'($urandom_range(1, 32'h430FFFFF));
         2:       return 32'($urandom);
         3:       return specials[$urandom_range(0, 6)];
         default: return 32'h43100000 + 32'($urandom_range(0, 255));
      endcase
   endfunction

   function automatic logic [127:0] kept128();
      logic [127:0] t;
      for (int i = 0; i < 4; i++) t[i*32 +: 32] = 32'($urandom_range(1, 32'h430FFFFF));
      return t;
   endfunction

   typedef struct {
      logic [31:0] r2;
      int          exp_rej;
      int          exp_out;
   } vec_t;

   initial begin
      vec_t         tbl [10];
      logic [127:0] t;
      logic [127:0] rv;
      int           nout;
      int           rej_total;
      int           nvalid;
      bit           saw_full;

      tbl[0] = '{32'h43100000, 1, 0};
      tbl[1] = '{32'h00000000, 1, 0};
      tbl[2] = '{32'h80000000, 1, 0};
      tbl[3] = '{32'hC1400000, 1, 0};
      tbl[4] = '{32'h7FC00000, 1, 0};
      tbl[5] = '{32'h7F800000, 1, 0};
      tbl[6] = '{32'h430FFFFF, 0, 1};
      tbl[7] = '{32'h00000001, 0, 1};
      tbl[8] = '{32'h41A80000, 0, 1};
      tbl[9] = '{32'hFF800000, 1, 0};

      rst = 1'b1;
      in_valid = '0; in_r2 = '0; in_dx = '0; in_dy = '0; in_dz = '0;
      idle();
      cycle(4'hF, {4{32'h41400000}}, rnd128(), rnd128(), rnd128());
      chk("reset_valid", 32'(r2_valid), 32'd0);
      chk("reset_rej", 32'(reject_count), 32'd0);
      rst = 1'b0;
      idle();
      chk("no_write_in_reset", 32'(r2_valid), 32'd0);

      // single pair on lane 0: visible two edges after acceptance, one-cycle pulse
      cycle(4'b0001, {96'h0, 32'h41A80000}, {96'h0, 32'h3F800000},
            {96'h0, 32'h40000000}, {96'h0, 32'h40800000});
      chk("lat_n1_valid", 32'(r2_valid), 32'd0);
      idle();
      chk("lat_valid", 32'(r2_valid), 32'd1);
      chk("lat_r2", r2, 32'h41A80000);
      chk("lat_dx", dx, 32'h3F800000);
      chk("lat_dy", dy, 32'h40000000);
      chk("lat_dz", dz, 32'h40800000);
      chk("lat_lane", 32'(out_lane), 32'd0);
      idle();
      chk("lat_pulse", 32'(r2_valid), 32'd0);
      chk("lat_hold_r2", r2, 32'h41A80000);

      // four lanes together, round-robin from lane 0, then lane 1 alone
      reset_pulse();
      cycle(4'hF, {4{32'h41400000}}, {32'd3, 32'd2, 32'd1, 32'd0}, '0, '0);
      for (int k = 0; k < 4; k++) begin
         idle();
         chk("rr_valid", 32'(r2_valid), 32'd1);
         chk("rr_lane", 32'(out_lane), 32'(k));
         chk("rr_dx", dx, 32'(k));
      end
      cycle(4'b0010, {64'h0, 32'h41400000, 32'h0}, {64'h0, 32'h55, 32'h0}, '0, '0);
      chk("rr_gap", 32'(r2_valid), 32'd0);
      idle();
      chk("rr_l1_valid", 32'(r2_valid), 32'd1);
      chk("rr_l1_lane", 32'(out_lane), 32'd1);
      chk("rr_l1_dx", dx, 32'h55);

      // filter table on lane 2
      reset_pulse();
      rej_total = 0;
      for (int v = 0; v < 10; v++) begin
         t = '0;
         t[64 +: 32] = tbl[v].r2;
         cycle(4'b0100, t, rnd128(), rnd128(), rnd128());
         nout = 0;
         for (int k = 0; k < 3; k++) begin
            idle();
            if (r2_valid) begin
               nout++;
               chk("tbl_r2", r2, tbl[v].r2);
               chk("tbl_lane", 32'(out_lane), 32'd2);
            end
         end
         rej_total += tbl[v].exp_rej;
         chk("tbl_outputs", 32'(nout), 32'(tbl[v].exp_out));
         chk("tbl_rejects", 32'(reject_count), 32'(rej_total));
         if (v == 4) chk("five_rejects", 32'(reject_count), 32'd5);
      end

      // all lanes every cycle: lanes fill, one output per cycle, order via model
      reset_pulse();
      saw_full = 1'b0;
      nvalid = 0;
      for (int c = 0; c < 20; c++) begin
         if (in_ready != 4'hF) saw_full = 1'b1;
         cycle(4'hF, kept128(), rnd128(), rnd128(), rnd128());
         if (c >= 1 && r2_valid) nvalid++;
      end
      chk("stream_full_seen", 32'(saw_full), 32'd1);
      chk("stream_throughput", 32'(nvalid), 32'd19);
      for (int c = 0; c < 40; c++) idle();
      chk("stream_drained", 32'(r2_valid), 32'd0);

      // randomized traffic against the model
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < 4; i++) rv[i*32 +: 32] = gen_r2();
         cycle(4'($urandom), rv, rnd128(), rnd128(), rnd128());
      end
      for (int c = 0; c < 40; c++) idle();

      // reset with six pairs buffered discards them
      reset_pulse();
      cycle(4'hF, kept128(), rnd128(), rnd128(), rnd128());
      cycle(4'b0111, kept128(), rnd128(), rnd128(), rnd128());
      rst = 1'b1;
      cycle(4'hF, kept128(), rnd128(), rnd128(), rnd128());
      rst = 1'b0;
      chk("mid_rst_valid", 32'(r2_valid), 32'd0);
      chk("mid_rst_rej", 32'(reject_count), 32'd0);
      chk("mid_rst_ready", 32'(in_ready), 32'hF);
      nvalid = 0;
      for (int c = 0; c < 10; c++) begin
         idle();
         if (r2_valid) nvalid++;
      end
      chk("mid_rst_no_stale", 32'(nvalid), 32'd0);

      // reject counter saturation: 4 rejects per cycle
      reset_pulse();
      for (int c = 0; c < 16383; c++) cycle(4'hF, '0, '0, '0, '0);
      chk("sat_before", 32'(reject_count), 32'd65532);
      cycle(4'hF, '0, '0, '0, '0);
      chk("sat_hit", 32'(reject_count), 32'h0000FFFF);
      cycle(4'hF, {4{32'h80000000}}, '0, '0, '0);
      chk("sat_hold", 32'(reject_count), 32'h0000FFFF);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/rl_pair_filter_arbiter.md
RL_PAIR_FILTER_ARBITER -- requirements
Module: rl_pair_filter_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning IEEE-754 single word width.
REQ-002 The block SHALL have parameter NUM_FILTER, default 4, meaning number of independent input lanes.
REQ-003 The block SHALL have parameter FILTER_ID_WIDTH, default 2, meaning log2(NUM_FILTER).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8, meaning entries per lane buffer.
REQ-005 The block SHALL have parameter FIFO_ADDR_WIDTH, default 3, meaning log2(FIFO_DEPTH).
REQ-006 The block SHALL have parameter CUTOFF_2, default 32'h43100000, meaning cutoff radius squared (144.0).
REQ-007 clk  input  1  single clock; all state updates on rising edge.
REQ-008 rst  input  1  reset, synchronous and active-high.
REQ-009 in_valid  input  NUM_FILTER  per-lane candidate pair valid.
REQ-010 in_r2  input  NUM_FILTER*DATA_WIDTH  per-lane r^2, lane i at bits [i*32+31:i*32].
REQ-011 in_dx, in_dy, in_dz  input  NUM_FILTER*DATA_WIDTH each  per-lane displacement components, same packing.
REQ-012 in_ready  output  NUM_FILTER  per-lane ready; lane i accepts when in_valid[i] & in_ready[i].
REQ-013 r2_valid  output  1  pair valid toward the RL evaluation pipeline.
REQ-014 r2, dx, dy, dz  output  DATA_WIDTH each  pair data toward the RL evaluation pipeline.
REQ-015 out_lane  output  FILTER_ID_WIDTH  source lane of current output pair.
REQ-016 reject_count  output  16  saturating count of filtered-out pairs, all lanes.

Function
REQ-017 Filter: an accepted pair SHALL be kept iff r2[31]==0 and r2[30:0]!=0 and r2[30:0] < CUTOFF_2[30:0] (unsigned integer compare); NaN/Inf, negative, +/-0 and r2>=cutoff SHALL be rejected.
REQ-018 Kept pairs SHALL be written into lane FIFO on the accepting edge; rejected pairs SHALL NOT be written and SHALL increment reject_count by the number of lanes rejecting that cycle, saturating at 16'hFFFF.
REQ-019 in_ready[i] SHALL equal NOT full of lane i FIFO (registered count < FIFO_DEPTH), independent of same-cycle pop.
REQ-020 in_valid[i] while in_ready[i]==0 SHALL be ignored (no write, no reject count).
REQ-021 Arbiter SHALL pop at most one entry per cycle, round-robin over non-empty FIFOs, starting search at lane (last_grant+1) mod NUM_FILTER.
REQ-022 Popped entry SHALL appear on r2, dx, dy, dz, out_lane with r2_valid=1 on the next cycle (registered outputs).
REQ-023 Latency: kept pair accepted in cycle N into all-empty block SHALL appear with r2_valid=1 in cycle N+2.
REQ-024 No pop cycle: r2_valid SHALL be 0; data outputs SHALL hold previous values.
REQ-025 Same-cycle push and pop on one FIFO SHALL both succeed; count unchanged; order preserved.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; per-lane FIFO order SHALL be strictly preserved.
REQ-027 Output has no backpressure: downstream accepts every r2_valid cycle; sustained throughput one pair per cycle.
REQ-028 last_grant SHALL update only on a pop.

Reset
REQ-029 While rst=1 at a rising edge: all FIFOs empty, pointers 0, last_grant=NUM_FILTER-1, r2_valid=0, r2/dx/dy/dz=0, out_lane=0, reject_count=0.
REQ-030 During reset, in_ready SHALL be all 1 (FIFOs empty) but no writes SHALL occur; rst mid-operation SHALL discard all buffered pairs, none emitted afterward.

Verification
REQ-031 Lane 0 single pair r2=41A80000 (21.0), dx=3F800000, dy=40000000, dz=40800000 -> two cycles later r2_valid=1, same values, out_lane=0, one-cycle pulse.
REQ-032 Lanes 0-3 one cycle, r2=41400000 (12.0) each -> four consecutive valid cycles, out_lane 0,1,2,3; then lane 1 alone -> out_lane=1 next.
REQ-033 Rejects: r2=43100000 (144.0), 00000000, 80000000, C1400000, 7FC00000 on lane 2 -> no r2_valid, reject_count=5.
REQ-034 Lanes 0-3 valid every cycle for 20 cycles -> in_ready[i] deasserts when lane count hits 8; no loss, per-lane order preserved, exactly one output per cycle.
REQ-035 rst asserted one cycle with 6 pairs buffered -> next cycle r2_valid=0, reject_count=0, in_ready=all 1; no stale pair ever emitted.
REQ-036 reject_count preloaded near saturation via 65535+ rejects -> holds 16'hFFFF.
